scroll_ctrl: RTL

Parametrised vertical scroll/score controller for the crossy-road VGA game. It converts the player's hold-to-move button into periodic scroll steps of the playfield, wraps the scroll offset modulo the screen height, and maintains a saturating BCD score. It also raises scroll speed in discrete levels as the score grows. It sits between the input pads and the obstacle/renderer blocks: `y_pos` feeds the background/lane renderer, and `step_pulse` drives follower obstacles.

---
 rtl/scroll_pkg.sv | 10 +
 rtl/bcd_counter.sv | 36 +++
 rtl/scroll_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/scroll_pkg.sv
// Shared types for the scroll controller: FSM state encoding and level width.
package scroll_pkg;
  localparam int LEVEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVING = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_counter.sv
// Packed BCD up-counter that saturates at all nines; digit 0 sits in the LSBs.
module bcd_counter #(
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                inc,
  output logic [4*DIGITS-1:0] q
);
  logic [4*DIGITS-1:0] r_q;
  logic [4*DIGITS-1:0] w_q_next;
  logic [DIGITS-1:0]   w_is9;
  logic [DIGITS-1:0]   w_carry;
  logic                w_sat;

  assign w_sat = &w_is9;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign w_is9[gi] = (r_q[4*gi +: 4] == 4'd9);
    // A digit advances when every lower digit is 9; computed flat to avoid a carry loop.
    if (gi == 0) begin : g_lsd
      assign w_carry[gi] = inc && !w_sat;
    end else begin : g_upper
      assign w_carry[gi] = inc && !w_sat && (&w_is9[gi-1:0]);
    end
    assign w_q_next[4*gi +: 4] = !w_carry[gi] ? r_q[4*gi +: 4]
                               : (w_is9[gi] ? 4'd0 : r_q[4*gi +: 4] + 4'd1);
  end

  always_ff @(posedge clk) begin
    if (clear) r_q <= '0;
    else       r_q <= w_q_next;
  end

  assign q = r_q;
endmodule

// File: rtl/scroll_ctrl.sv
// Vertical scroll/score controller: turns a held move button into periodic
// scroll steps, wraps the offset and keeps a saturating BCD score and speed level.
module scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int Y_W              = 10,
  parameter int SCREEN_H         = 480,
  parameter int TICK_CYCLES      = 100000,
  parameter int STEP_MIN         = 2,
  parameter int STEP_MAX         = 6,
  parameter int STEPS_PER_POINT  = 100,
  parameter int POINTS_PER_LEVEL = 10,
  parameter int SCORE_DIGITS     = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      move_btn,
  input  logic                      pause,
  output logic [Y_W-1:0]            y_pos,
  output logic [4*SCORE_DIGITS-1:0] score,
  output logic [LEVEL_W-1:0]        level,
  output logic                      step_pulse,
  output logic                      wrap_pulse
);
  localparam int TICK_W      = $clog2(TICK_CYCLES);
  localparam int SPP_W       = (STEPS_PER_POINT > 1) ? $clog2(STEPS_PER_POINT) : 1;
  localparam int PPL_W       = (POINTS_PER_LEVEL > 1) ? $clog2(POINTS_PER_LEVEL) : 1;
  localparam int YS_W        = Y_W + 1;
  localparam int LEVEL_MAX_I = (STEP_MAX - STEP_MIN > 7) ? 7 : STEP_MAX - STEP_MIN;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_CYCLES - 1);
  localparam logic [SPP_W-1:0]   SPP_LAST   = SPP_W'(STEPS_PER_POINT - 1);
  localparam logic [PPL_W-1:0]   PPL_LAST   = PPL_W'(POINTS_PER_LEVEL - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(LEVEL_MAX_I);
  localparam logic [YS_W-1:0]    SCREEN_H_X = YS_W'(SCREEN_H);

  logic               r_sync1;
  logic               r_sync2;
  logic               w_move_s;
  state_t             r_state;
  state_t             w_state_next;
  logic [TICK_W-1:0]  r_tick;
  logic [TICK_W-1:0]  w_tick_next;
  logic               w_step;
  logic [SPP_W-1:0]   r_step_cnt;
  logic [PPL_W-1:0]   r_pt_cnt;
  logic [LEVEL_W-1:0] r_level;
  logic [Y_W-1:0]     r_y;
  logic [Y_W-1:0]     w_y_next;
  logic [YS_W-1:0]    w_step_amt;
  logic [YS_W-1:0]    w_y_sum;
  logic               w_wrap;
  logic               w_point;
  logic               w_level_up;
  logic               r_step_pulse;
  logic               r_wrap_pulse;

  assign w_move_s = r_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= ST_IDLE;
      r_tick  <= '0;
    end else begin
      r_sync1 <= move_btn;
      r_sync2 <= r_sync1;
      r_state <= w_state_next;
      r_tick  <= w_tick_next;
    end
  end

  // Pause wins over movement; a step fires only while staying in MOVING.
  always_comb begin
    w_state_next = r_state;
    w_tick_next  = r_tick;
    w_step       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tick_next = '0;
        if (pause)         w_state_next = ST_PAUSED;
        else if (w_move_s) w_state_next = ST_MOVING;
      end
      ST_MOVING: begin
        if (pause) begin
          w_state_next = ST_PAUSED;
        end else if (!w_move_s) begin
          w_state_next = ST_IDLE;
          w_tick_next  = '0;
        end else if (r_tick == TICK_LAST) begin
          w_tick_next = '0;
          w_step      = 1'b1;
        end else begin
          w_tick_next = r_tick + TICK_W'(1);
        end
      end
      ST_PAUSED: begin
        if (!pause) begin
          if (w_move_s) begin
            w_state_next = ST_MOVING;
          end else begin
            w_state_next = ST_IDLE;
            w_tick_next  = '0;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_tick_next  = '0;
      end
    endcase
  end

  always_comb begin
    if (int'(r_level) + STEP_MIN >= STEP_MAX) w_step_amt = YS_W'(STEP_MAX);
    else                                      w_step_amt = YS_W'(STEP_MIN) + YS_W'(r_level);
  end

  assign w_y_sum    = {1'b0, r_y} + w_step_amt;
  assign w_wrap     = (w_y_sum >= SCREEN_H_X);
  assign w_y_next   = w_wrap ? Y_W'(w_y_sum - SCREEN_H_X) : Y_W'(w_y_sum);
  assign w_point    = w_step && (r_step_cnt == SPP_LAST);
  assign w_level_up = w_point && (r_pt_cnt == PPL_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_y          <= '0;
      r_step_cnt   <= '0;
      r_pt_cnt     <= '0;
      r_level      <= '0;
      r_step_pulse <= 1'b0;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_step_pulse <= w_step;
      r_wrap_pulse <= w_step && w_wrap;
      if (w_step) begin
        r_y        <= w_y_next;
        r_step_cnt <= w_point ? '0 : r_step_cnt + SPP_W'(1);
      end
      // Point counter keeps running even once the score has saturated.
      if (w_point) r_pt_cnt <= w_level_up ? '0 : r_pt_cnt + PPL_W'(1);
      if (w_level_up && (r_level < LEVEL_MAX)) r_level <= r_level + LEVEL_W'(1);
    end
  end

  bcd_counter #(
    .DIGITS (SCORE_DIGITS)
  ) u_score (
    .clk   (clk),
    .clear (reset),
    .inc   (w_point),
    .q     (score)
  );

  assign y_pos      = r_y;
  assign level      = r_level;
  assign step_pulse = r_step_pulse;
  assign wrap_pulse = r_wrap_pulse;
endmodule
